// File: rtl/fifo_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fifo_axi_pkg
// Purpose : Shared definitions for the FIFO-to-SRAM write arbiter:
//           - word_w()          : packed word width {tlast, 8b keep, tdata}
//           - state_e           : burst FSM state encoding
//           - BURST_LEN_DEFAULT : default number of words per SRAM burst
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package fifo_axi_pkg;

  localparam int BURST_LEN_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // TDATA width is given in bytes; each word carries 8*bytes of data,
  // an 8-bit keep field and one tlast bit.
  function automatic int word_w(input int tdata_bytes);
    return 8 * tdata_bytes + 9;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : fifo_rr_arbiter
// Purpose : Combinational round-robin pick. Scans last_i+1, last_i+2, ...
//           (mod NUM_QUEUES) and returns the first requesting index.
// Ports   : req_i   [NUM_QUEUES]     request vector
//           last_i  [QUEUE_ID_WIDTH] most recently served queue
//           grant_o [QUEUE_ID_WIDTH] chosen queue (0 when any_o is low)
//           any_o                    at least one request present
// Revision: 1.0 - initial release
// ============================================================================
module fifo_rr_arbiter #(
  parameter int NUM_QUEUES     = 4,
  parameter int QUEUE_ID_WIDTH = 2
) (
  input  logic [NUM_QUEUES-1:0]     req_i,
  input  logic [QUEUE_ID_WIDTH-1:0] last_i,
  output logic [QUEUE_ID_WIDTH-1:0] grant_o,
  output logic                      any_o
);

  logic [QUEUE_ID_WIDTH-1:0] idx;
  logic                      found;

  // Offset 1 is examined first so the previous winner has the lowest
  // priority; offset NUM_QUEUES wraps back to last_i itself, which lets a
  // lone requester be served back-to-back.
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int off = 1; off <= NUM_QUEUES; off++) begin
      idx = QUEUE_ID_WIDTH'((int'(last_i) + off) % NUM_QUEUES);
      if (!found && req_i[idx]) begin
        grant_o = idx;
        found   = 1'b1;
      end
    end
    any_o = found;
  end

endmodule
`default_nettype wire

// File: rtl/fifo_axi_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : fifo_axi_write_arbiter
// Purpose : Collects fixed BURST_LEN-word bursts from NUM_QUEUES per-queue
//           FWFT input FIFOs and writes them, one burst at a time, into the
//           SRAM write path. Queues are served round-robin among those that
//           hold a full burst and have SRAM room for it. A one-cycle
//           burst_inc_o pulse marks each completed burst.
// Ports   : memclk, reset         clock / synchronous active-high reset
//           in_burst_avail_i [N]  input FIFO i holds >= BURST_LEN words
//           in_data_i  [N*W]      head word of each input FIFO (slice i)
//           in_rd_en_o [N]        pop strobe to input FIFO i
//           mem_queue_full_i [N]  SRAM queue i cannot take another burst
//           mem_wr_valid_o / mem_wr_ready_i  output handshake
//           mem_din_o [W], mem_queue_id_o, mem_wr_first_o  output word
//           burst_inc_o [N]       burst fully accepted for queue i
//           burst_count_o [N*32]  per-queue burst counters (optional)
// Config  : define FIFOAXI_WR_STATS_EN to add burst_count_o.
// Revision: 1.0 - initial release
// ============================================================================
module fifo_axi_write_arbiter
  import fifo_axi_pkg::*;
#(
  parameter  int TDATA_WIDTH    = 32,
  parameter  int NUM_QUEUES     = 4,
  parameter  int QUEUE_ID_WIDTH = 2,
  parameter  int BURST_LEN      = BURST_LEN_DEFAULT,
  localparam int WORD_W         = word_w(TDATA_WIDTH)
) (
  input  logic                         memclk,
  input  logic                         reset,
  input  logic [NUM_QUEUES-1:0]        in_burst_avail_i,
  input  logic [NUM_QUEUES*WORD_W-1:0] in_data_i,
  output logic [NUM_QUEUES-1:0]        in_rd_en_o,
  input  logic [NUM_QUEUES-1:0]        mem_queue_full_i,
  output logic                         mem_wr_valid_o,
  input  logic                         mem_wr_ready_i,
  output logic [WORD_W-1:0]            mem_din_o,
  output logic [QUEUE_ID_WIDTH-1:0]    mem_queue_id_o,
  output logic                         mem_wr_first_o,
  output logic [NUM_QUEUES-1:0]        burst_inc_o
`ifdef FIFOAXI_WR_STATS_EN
  ,
  output logic [NUM_QUEUES*32-1:0]     burst_count_o
`endif
);

  localparam int                        CNT_W    = $clog2(BURST_LEN);
  localparam logic [CNT_W-1:0]          CNT_LAST = CNT_W'(BURST_LEN - 1);
  localparam logic [QUEUE_ID_WIDTH-1:0] Q_LAST   = QUEUE_ID_WIDTH'(NUM_QUEUES - 1);

  state_e                    state_q, state_d;
  logic [QUEUE_ID_WIDTH-1:0] cur_queue_q;
  logic [QUEUE_ID_WIDTH-1:0] last_queue_q;
  logic [CNT_W-1:0]          cnt_q;
  logic                      valid_q;
  logic [WORD_W-1:0]         din_q;
  logic [QUEUE_ID_WIDTH-1:0] qid_q;
  logic                      first_q;
  logic [NUM_QUEUES-1:0]     burst_inc_q;

  logic [NUM_QUEUES-1:0]     eligible;
  logic [QUEUE_ID_WIDTH-1:0] grant;
  logic                      grant_any;
  logic                      pop;

  logic [WORD_W-1:0]         in_word [NUM_QUEUES];

  for (genvar gi = 0; gi < NUM_QUEUES; gi++) begin : g_unpack
    assign in_word[gi] = in_data_i[gi*WORD_W +: WORD_W];
  end

  assign eligible = in_burst_avail_i & ~mem_queue_full_i;

  fifo_rr_arbiter #(
    .NUM_QUEUES     (NUM_QUEUES),
    .QUEUE_ID_WIDTH (QUEUE_ID_WIDTH)
  ) u_rr (
    .req_i   (eligible),
    .last_i  (last_queue_q),
    .grant_o (grant),
    .any_o   (grant_any)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge memclk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (grant_any) state_d = ST_BURST;
      ST_BURST: if (pop && (cnt_q == CNT_LAST)) state_d = ST_DRAIN;
      ST_DRAIN: if (mem_wr_ready_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. A word is pulled whenever the output register is empty or
  // being emptied this cycle. Pops are suppressed under reset so no input
  // word is consumed by a burst that is being thrown away.
  // --------------------------------------------------------------------------
  always_comb begin
    pop        = 1'b0;
    in_rd_en_o = '0;
    if ((state_q == ST_BURST) && !reset) begin
      pop                     = ~valid_q | mem_wr_ready_i;
      in_rd_en_o[cur_queue_q] = pop;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath and bookkeeping registers
  // --------------------------------------------------------------------------
  always_ff @(posedge memclk) begin
    if (reset) begin
      cur_queue_q  <= '0;
      last_queue_q <= Q_LAST;
      cnt_q        <= '0;
      valid_q      <= 1'b0;
      din_q        <= '0;
      qid_q        <= '0;
      first_q      <= 1'b0;
      burst_inc_q  <= '0;
    end else begin
      burst_inc_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (grant_any) begin
            cur_queue_q <= grant;
            cnt_q       <= '0;
          end
        end
        ST_BURST: begin
          if (pop) begin
            din_q   <= in_word[cur_queue_q];
            qid_q   <= cur_queue_q;
            first_q <= (cnt_q == '0);
            valid_q <= 1'b1;
            // Holds at the last index; IDLE clears it before the next burst.
            if (cnt_q != CNT_LAST) begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (mem_wr_ready_i) begin
            valid_q                  <= 1'b0;
            burst_inc_q[cur_queue_q] <= 1'b1;
            last_queue_q             <= cur_queue_q;
          end
        end
        default: begin
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_wr_valid_o = valid_q;
  assign mem_din_o      = din_q;
  assign mem_queue_id_o = qid_q;
  assign mem_wr_first_o = first_q;
  assign burst_inc_o    = burst_inc_q;

`ifdef FIFOAXI_WR_STATS_EN
  for (genvar gs = 0; gs < NUM_QUEUES; gs++) begin : g_stats
    logic [31:0] count_q;
    always_ff @(posedge memclk) begin
      if (reset) begin
        count_q <= '0;
      end else if (burst_inc_q[gs]) begin
        count_q <= count_q + 32'd1;
      end
    end
    assign burst_count_o[gs*32 +: 32] = count_q;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_axi_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_axi_write_arbiter
// Purpose : Scoreboard bench. Input FIFOs are modelled as arrays; a
//           burst-level round-robin model predicts the full output word
//           stream and burst_inc sequence, and a negedge monitor compares.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fifo_axi_write_arbiter;

  localparam int WW = 8 * 32 + 9;
  localparam int NQ = 4;
  localparam int BL = 4;

  typedef struct {
    logic [WW-1:0] d;
    logic [1:0]    q;
    logic          first;
    logic          last;
  } exp_t;

  logic              memclk;
  logic              reset;
  logic [NQ-1:0]     in_avail;
  logic [NQ*WW-1:0]  in_data;
  logic [NQ-1:0]     in_rd_en;
  logic [NQ-1:0]     full;
  logic              valid;
  logic              ready;
  logic [WW-1:0]     din;
  logic [1:0]        qid;
  logic              first;
  logic [NQ-1:0]     burst_inc;
`ifdef FIFOAXI_WR_STATS_EN
  logic [NQ*32-1:0]  burst_count;
`endif

  fifo_axi_write_arbiter #(
    .TDATA_WIDTH(32), .NUM_QUEUES(NQ), .QUEUE_ID_WIDTH(2), .BURST_LEN(BL)
  ) dut (
    .memclk           (memclk),
    .reset            (reset),
    .in_burst_avail_i (in_avail),
    .in_data_i        (in_data),
    .in_rd_en_o       (in_rd_en),
    .mem_queue_full_i (full),
    .mem_wr_valid_o   (valid),
    .mem_wr_ready_i   (ready),
    .mem_din_o        (din),
    .mem_queue_id_o   (qid),
    .mem_wr_first_o   (first),
    .burst_inc_o      (burst_inc)
`ifdef FIFOAXI_WR_STATS_EN
    ,
    .burst_count_o    (burst_count)
`endif
  );

  // ---------------- bench state ----------------
  logic [WW-1:0] mem [NQ][256];
  int            wr_ptr [NQ];
  int            rd_ptr [NQ];
  int            m_rd   [NQ];
  int            m_last;
  int            stat   [NQ];
  logic [NQ-1:0] mask;
  logic [NQ-1:0] rd_snap;
  int            rmode, rph;

  exp_t          exp_w[$];
  int            exp_b[$];
  logic [1:0]    glog[$];
  int            acc_t[$];
  int            acc_n, pop_n, cyc;
  logic          mon_en, p_stall, p_last;
  logic [WW-1:0] p_din;

  int total, bad;

  task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%h req=%h", nm, act, req);
    end
  endtask

  // ---------------- input FIFO model ----------------
  always_comb begin
    in_data  = '0;
    in_avail = '0;
    for (int q = 0; q < NQ; q++) begin
      in_data[q*WW +: WW] = mem[q][rd_ptr[q] % 256];
      in_avail[q]         = mask[q] && ((wr_ptr[q] - rd_ptr[q]) >= BL);
    end
  end

  task automatic fill(input int q, input int nb);
    logic [287:0] t;
    for (int k = 0; k < nb * BL; k++) begin
      for (int j = 0; j < 9; j++) t[j*32 +: 32] = $urandom;
      mem[q][wr_ptr[q] % 256] = t[WW-1:0];
      wr_ptr[q]++;
    end
  endtask

  // Burst-level reference: repeatedly hand a whole burst to the next queue
  // after the last winner that is enabled, not full and still has a burst.
  task automatic plan();
    bit found;
    int q;
    exp_t e;
    do begin
      found = 0;
      for (int off = 1; off <= NQ && !found; off++) begin
        q = (m_last + off) % NQ;
        if (mask[q] && !full[q] && (wr_ptr[q] - m_rd[q]) >= BL) begin
          found = 1;
          for (int k = 0; k < BL; k++) begin
            e.d = mem[q][m_rd[q] % 256];
            e.q = 2'(q);
            e.first = (k == 0);
            e.last  = (k == BL - 1);
            exp_w.push_back(e);
            m_rd[q]++;
          end
          exp_b.push_back(q);
          stat[q]++;
          m_last = q;
        end
      end
    end while (found);
  endtask

  task automatic flush();
    for (int q = 0; q < NQ; q++) begin
      rd_ptr[q] = wr_ptr[q];
      m_rd[q]   = wr_ptr[q];
      stat[q]   = 0;
    end
    exp_w.delete();
    exp_b.delete();
    m_last  = NQ - 1;
    p_stall = 0;
    p_last  = 0;
    mon_en  = 1;
  endtask

  task automatic do_reset();
    @(posedge memclk); #1;
    reset = 1; mon_en = 0; mask = '0; full = '0;
    repeat (2) @(posedge memclk);
    #1;
    reset = 0;
    flush();
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_w.size() != 0 || exp_b.size() != 0) && n < 3000) begin
      @(posedge memclk);
      n++;
    end
    chk("drain_timeout", WW'(n < 3000), WW'(1));
    repeat (4) @(posedge memclk);
    #1;
  endtask

  // ---------------- clock, cycle count, ready, FIFO pops ----------------
  initial begin
    memclk = 0;
    forever #5 memclk = ~memclk;
  end

  initial forever begin
    @(posedge memclk);
    cyc++;
  end

  initial forever begin
    @(posedge memclk); #1;
    case (rmode)
      1:       begin ready = (rph == 0) || (rph == 3); rph = (rph + 1) % 4; end
      2:       ready = ($urandom_range(0, 2) != 0);
      default: ready = 1'b1;
    endcase
  end

  initial forever begin
    @(negedge memclk);
    rd_snap = in_rd_en;
  end

  initial forever begin
    @(posedge memclk); #1;
    for (int q = 0; q < NQ; q++) begin
      if (rd_snap[q]) begin
        rd_ptr[q]++;
        pop_n++;
      end
    end
  end

  // ---------------- monitor ----------------
  initial forever begin
    @(negedge memclk);
    if (mon_en) begin
      exp_t          e;
      int            bq;
      logic [NQ-1:0] oh;
      if (p_last) begin
        if (exp_b.size() == 0) chk("burst_inc_unexpected", WW'(burst_inc), '0);
        else begin
          bq = exp_b.pop_front();
          oh = '0;
          oh[bq] = 1'b1;
          chk("burst_inc", WW'(burst_inc), WW'(oh));
        end
      end else if (burst_inc != '0) begin
        chk("burst_inc_spurious", WW'(burst_inc), '0);
      end
      if (p_stall) begin
        chk("stall_valid", WW'(valid), WW'(1));
        chk("stall_din", din, p_din);
      end
      p_last = 0;
      if (valid && ready) begin
        acc_n++;
        acc_t.push_back(cyc);
        if (first) glog.push_back(qid);
        if (exp_w.size() == 0) chk("word_unexpected", WW'(1), '0);
        else begin
          e = exp_w.pop_front();
          chk("word_data", din, e.d);
          chk("word_qid", WW'(qid), WW'(e.q));
          chk("word_first", WW'(first), WW'(e.first));
          p_last = e.last;
        end
      end
      p_stall = valid && !ready;
      p_din   = din;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int lat, p0, base, n;
    total = 0; bad = 0; cyc = 0; acc_n = 0; pop_n = 0;
    reset = 1; mask = '0; full = '0; ready = 1; rmode = 0; rph = 0;
    mon_en = 0; p_stall = 0; p_last = 0; rd_snap = '0;
    for (int q = 0; q < NQ; q++) begin
      wr_ptr[q] = 0; rd_ptr[q] = 0; m_rd[q] = 0; stat[q] = 0;
    end
    m_last = NQ - 1;
    repeat (3) @(posedge memclk);
    #1;
    reset = 0;
    @(negedge memclk);
    chk("rst_valid", WW'(valid), '0);
    chk("rst_din", din, '0);
    chk("rst_qid", WW'(qid), '0);
    chk("rst_first", WW'(first), '0);
    chk("rst_burst_inc", WW'(burst_inc), '0);
    chk("rst_rd_en", WW'(in_rd_en), '0);
    flush();

    // 1: single queue q2, latency and back-to-back words
    fill(2, 1);
    @(posedge memclk); #1;
    acc_t.delete();
    mask = 4'b0100;
    plan();
    lat = 0;
    do begin
      @(posedge memclk); #2;
      lat++;
    end while (!valid && lat < 10);
    chk("t1_first_latency", WW'(lat), WW'(2));
    wait_drain();
    chk("t1_accepts", WW'(acc_t.size()), WW'(4));
    if (acc_t.size() == 4) chk("t1_consecutive", WW'(acc_t[3] - acc_t[0]), WW'(3));

    // 2: all queues eligible after reset -> 0,1,2,3,0
    do_reset();
    fill(0, 2); fill(1, 1); fill(2, 1); fill(3, 1);
    glog.delete();
    mask = 4'b1111;
    plan();
    wait_drain();
    chk("t2_bursts", WW'(glog.size()), WW'(5));
    if (glog.size() == 5) begin
      chk("t2_g0", WW'(glog[0]), WW'(0));
      chk("t2_g1", WW'(glog[1]), WW'(1));
      chk("t2_g2", WW'(glog[2]), WW'(2));
      chk("t2_g3", WW'(glog[3]), WW'(3));
      chk("t2_g4", WW'(glog[4]), WW'(0));
    end

    // 3: ready pattern 1,0,0,1 stalls the burst
    mask = '0;
    fill(3, 1);
    rph = 0; rmode = 1;
    p0 = pop_n;
    mask = 4'b1000;
    plan();
    wait_drain();
    chk("t3_pops", WW'(pop_n - p0), WW'(4));
    rmode = 0;

    // 4: q1 blocked by SRAM full, then released
    mask = '0;
    fill(0, 2); fill(1, 1);
    full = 4'b0010;
    glog.delete();
    mask = 4'b0011;
    plan();
    wait_drain();
    chk("t4_blocked_bursts", WW'(glog.size()), WW'(2));
    foreach (glog[i]) chk("t4_only_q0", WW'(glog[i]), WW'(0));
    glog.delete();
    full = '0;
    plan();
    wait_drain();
    chk("t4_release_bursts", WW'(glog.size()), WW'(1));
    if (glog.size() == 1) chk("t4_release_q1", WW'(glog[0]), WW'(1));

    // random phases: masks, full flags, burst counts and ready
    rmode = 2;
    for (int ph = 0; ph < 6; ph++) begin
      mask = '0;
      for (int q = 0; q < NQ; q++) fill(q, $urandom_range(0, 2));
      full = 4'($urandom);
      mask = 4'($urandom);
      plan();
      wait_drain();
    end
    full = '0; mask = 4'b1111;
    plan();
    wait_drain();
    rmode = 0;

    // 5: reset in the middle of a burst
    do_reset();
    fill(0, 1);
    base = acc_n;
    mask = 4'b0001;
    plan();
    n = 0;
    while (acc_n < base + 3 && n < 100) begin
      @(negedge memclk);
      n++;
    end
    chk("t5_wait", WW'(n < 100), WW'(1));
    @(posedge memclk); #1;
    reset = 1; mon_en = 0;
    @(posedge memclk); #1;
    reset = 0; mask = '0;
    flush();
    @(negedge memclk);
    chk("t5_valid", WW'(valid), '0);
    chk("t5_din", din, '0);
    chk("t5_qid", WW'(qid), '0);
    chk("t5_first", WW'(first), '0);
    chk("t5_burst_inc", WW'(burst_inc), '0);
    chk("t5_rd_en", WW'(in_rd_en), '0);
    @(posedge memclk); #1;
    for (int q = 0; q < NQ; q++) fill(q, 1);
    glog.delete();
    mask = 4'b1111;
    plan();
    wait_drain();
    chk("t5_bursts", WW'(glog.size()), WW'(4));
    if (glog.size() == 4) begin
      chk("t5_g0", WW'(glog[0]), WW'(0));
      chk("t5_g3", WW'(glog[3]), WW'(3));
    end

    // 6: three bursts on q3
    do_reset();
    fill(3, 3);
    mask = 4'b1000;
    plan();
    wait_drain();
`ifdef FIFOAXI_WR_STATS_EN
    for (int q = 0; q < NQ; q++) chk("t6_burst_count", WW'(burst_count[q*32 +: 32]), WW'(stat[q]));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
